adaptive_threshold: RTL and testbench
=====================================

Name: adaptive_threshold

Overview:
- Consumer of the 3x3 mean image produced by the box filter stage.
- Scans every pixel once and reads the original image and the mean image at the same address.
- Writes a binary output image (255/0) to the output memory, with a white-pixel count.
- Started by the box filter's finished pulse or level. Raster order: row-major, col fastest. Fully pipelined, one pixel per clock.

Parameters:
- WIDTH_BITS, 7, column address width.
- HEIGHT_BITS, 7, row address width.
- WIDTH, 2**WIDTH_BITS, image width in pixels.
- HEIGHT, 2**HEIGHT_BITS, image height in pixels.

Ports:
- clock  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- iStart  in  1  level; sampled in IDLE/DONE, begins a pass.
- iOffset  in  8  threshold offset C; latched on the accepting iStart edge.
- oReadCol  out  WIDTH_BITS  column address, shared by the image and mean memories.
- oReadRow  out  HEIGHT_BITS  row address, shared by both memories.
- iImageData  in  8  original pixel; registered memory output, valid 1 cycle after address.
- iMeanData  in  8  mean pixel; same latency as iImageData.
- oResultCol  out  WIDTH_BITS  output memory column.
- oResultRow  out  HEIGHT_BITS  output memory row.
- oResultData  out  8  255 or 0.
- oResultWren  out  1  output memory write enable, one cycle per pixel.
- oBusy  out  1  high from accepted start until finished rises.
- finished  out  1  sticky high after a complete pass.
- oWhiteCount  out  WIDTH_BITS+HEIGHT_BITS+1  number of 255 pixels written in the last or current pass.

Behaviour:
- Reset (async): state IDLE; all outputs 0, including addresses, data, wren, busy, finished and count; pipeline valids cleared; latched C = 0.
- Reset mid-pass: aborts immediately. No further writes; restart requires a new iStart.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE, iStart=1 at edge k:
  - latch C = iOffset; pos = 0; count = 0; finished = 0; oBusy = 1; go RUN.
- RUN: read address = pos (registered, so address 0 is visible after edge k).
  - Each edge, pos++ and a stage-1 valid is issued.
  - When pos == WIDTH*HEIGHT-1 is issued, go DRAIN.
  - iStart is ignored in RUN and DRAIN.
- Pipeline, per pixel with address presented after edge t:
  - Stage 1 (edge t+1): data arrives; address is delayed 1 stage alongside it.
  - Stage 2 (edge t+2): register oResultData, oResultCol, oResultRow; oResultWren = 1 for one cycle; count += (result == 255).
- Compare rule: result = 255 iff {1'b0,pixel} + {1'b0,C} > {1'b0,mean}, in 9-bit unsigned arithmetic. No wrap or underflow.
  - pixel+C == mean gives 0.
  - C = 0 degenerates to pixel > mean.
- Latency: first wren high after edge k+2.
  - Writes occur in N = WIDTH*HEIGHT consecutive cycles, the last after edge k+N+1.
- DRAIN: wait until both stage valids are 0.
  - At edge k+N+2: state DONE, finished = 1, oBusy = 0, oResultWren = 0.
- DONE: finished and oWhiteCount held until reset or a new accepted iStart.
- iStart held high continuously from DONE immediately starts a new pass (finished drops at the accepting edge).
- oResultData/Col/Row hold their last values when wren = 0.
- Count never overflows: width covers N.

Decomposition:
- Shared package:
  - PIXEL_WHITE = 8'hFF, PIXEL_BLACK = 8'h00.
  - State enum {IDLE, RUN, DRAIN, DONE}.
  - Pixel-index width expression WIDTH_BITS+HEIGHT_BITS.
- Sub-module threshold_cmp: combinational pixel/mean/C to 8-bit result.
  - Isolates the 9-bit compare rule for unit checking.
  - Reusable by later variants such as inverted or Gaussian-mean thresholding.

Test Plan:
- WIDTH_BITS=HEIGHT_BITS=2 (N=16), uniform pixel=100 and mean=100, C=0 -> 16 writes of 0 in consecutive cycles at addresses (0,0)..(3,3) in raster order; count=0; finished rises 1 cycle after the last wren.
- Same image with C=1 -> all 16 writes are 255, count=16. Timing: iStart edge k, first wren after k+2, finished after k+18.
- Boundary values: pixel=0, mean=3, C=5 -> 255; pixel=255, C=255, mean=255 -> 255; pixel=10, C=0, mean=10 -> 0; pixel=0, C=0, mean=0 -> 0.
- Pulse iStart during RUN with a different iOffset -> ignored: pass uses the original C, still exactly 16 writes, no address restart.
- Assert reset after 5 writes -> outputs 0 the same cycle, no further wren, finished stays 0; new iStart -> full 16-write pass from (0,0).
- Hold iStart high in DONE -> second pass starts, finished clears at the accepting edge, count resets and re-accumulates to the same value.

Source files
------------

// File: rtl/adaptive_threshold_pkg.sv
// Shared definitions for the adaptive threshold stage: output pixel levels,
// controller state encoding and the pixel-index width helper.
package adaptive_threshold_pkg;

  localparam logic [7:0] PIXEL_WHITE = 8'hFF;
  localparam logic [7:0] PIXEL_BLACK = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of a linear pixel index (row bits on top of column bits).
  function automatic int idx_bits(input int width_bits, input int height_bits);
    return width_bits + height_bits;
  endfunction

endpackage

// File: rtl/threshold_cmp.sv
// Combinational threshold decision: white when pixel + C exceeds the local
// mean. The sum is formed in 9 bits so large offsets never wrap around.
module threshold_cmp
  import adaptive_threshold_pkg::*;
(
  input  logic [7:0] pixel,
  input  logic [7:0] mean,
  input  logic [7:0] offset,
  output logic [7:0] result
);

  logic [8:0] biased_sum;

  assign biased_sum = {1'b0, pixel} + {1'b0, offset};
  // A tie (pixel + C == mean) is black.
  assign result = (biased_sum > {1'b0, mean}) ? PIXEL_WHITE : PIXEL_BLACK;

endmodule

// File: rtl/adaptive_threshold.sv
// Adaptive threshold stage: walks every pixel once in raster order, reads the
// original and mean images at the same address and writes a 255/0 image plus
// a count of white pixels. One pixel per clock through a two-stage pipeline:
// address register -> memory data (stage 1) -> result register (stage 2).
module adaptive_threshold
  import adaptive_threshold_pkg::*;
#(
  parameter int WIDTH_BITS  = 7,
  parameter int HEIGHT_BITS = 7
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              iStart,
  input  logic [7:0]                        iOffset,
  output logic [WIDTH_BITS-1:0]             oReadCol,
  output logic [HEIGHT_BITS-1:0]            oReadRow,
  input  logic [7:0]                        iImageData,
  input  logic [7:0]                        iMeanData,
  output logic [WIDTH_BITS-1:0]             oResultCol,
  output logic [HEIGHT_BITS-1:0]            oResultRow,
  output logic [7:0]                        oResultData,
  output logic                              oResultWren,
  output logic                              oBusy,
  output logic                              finished,
  output logic [WIDTH_BITS+HEIGHT_BITS:0]   oWhiteCount
);

  localparam int IDX_BITS = idx_bits(WIDTH_BITS, HEIGHT_BITS);
  localparam int CNT_BITS = IDX_BITS + 1;
  // The image is a power-of-two size, so the last index is all ones.
  localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

  state_t state_reg, state_next;

  logic                accept;
  logic                issue;
  logic                finish;

  logic [7:0]          offset_reg;
  logic [IDX_BITS-1:0] pos_reg;
  logic                s1_valid_reg;
  logic [IDX_BITS-1:0] s1_pos_reg;
  logic                wren_reg;
  logic [IDX_BITS-1:0] res_pos_reg;
  logic [7:0]          res_data_reg;
  logic [CNT_BITS-1:0] count_reg;
  logic                busy_reg;
  logic                finished_reg;
  logic [7:0]          cmp_result;

  threshold_cmp u_cmp (
    .pixel  (iImageData),
    .mean   (iMeanData),
    .offset (offset_reg),
    .result (cmp_result)
  );

  // Controller state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; iStart only matters when no pass is in flight.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (iStart) state_next = RUN;
      RUN:        if (pos_reg == LAST_IDX) state_next = DRAIN;
      // Stage 2 empties on the same edge that stage 1 is seen empty.
      DRAIN:      if (!s1_valid_reg) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    accept = 1'b0;
    issue  = 1'b0;
    finish = 1'b0;
    case (state_reg)
      IDLE, DONE: accept = iStart;
      RUN:        issue  = 1'b1;
      DRAIN:      finish = !s1_valid_reg;
      default:    ;
    endcase
  end

  // Read address generator and stage-1 valid/address tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      offset_reg   <= 8'd0;
      pos_reg      <= '0;
      s1_valid_reg <= 1'b0;
      s1_pos_reg   <= '0;
    end else begin
      s1_valid_reg <= issue;
      if (accept) begin
        offset_reg <= iOffset;
        pos_reg    <= '0;
      end
      if (issue) begin
        s1_pos_reg <= pos_reg;
        // Hold on the last address; the state machine leaves RUN here.
        if (pos_reg != LAST_IDX) pos_reg <= pos_reg + IDX_BITS'(1);
      end
    end
  end

  // Stage 2: register the decision and write strobe; accumulate whites.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wren_reg     <= 1'b0;
      res_pos_reg  <= '0;
      res_data_reg <= 8'd0;
      count_reg    <= '0;
    end else begin
      wren_reg <= s1_valid_reg;
      if (accept) count_reg <= '0;
      if (s1_valid_reg) begin
        res_pos_reg  <= s1_pos_reg;
        res_data_reg <= cmp_result;
        if (cmp_result == PIXEL_WHITE) count_reg <= count_reg + CNT_BITS'(1);
      end
    end
  end

  // Busy / finished status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_reg     <= 1'b0;
      finished_reg <= 1'b0;
    end else if (accept) begin
      busy_reg     <= 1'b1;
      finished_reg <= 1'b0;
    end else if (finish) begin
      busy_reg     <= 1'b0;
      finished_reg <= 1'b1;
    end
  end

  assign oReadCol    = pos_reg[WIDTH_BITS-1:0];
  assign oReadRow    = pos_reg[IDX_BITS-1:WIDTH_BITS];
  assign oResultCol  = res_pos_reg[WIDTH_BITS-1:0];
  assign oResultRow  = res_pos_reg[IDX_BITS-1:WIDTH_BITS];
  assign oResultData = res_data_reg;
  assign oResultWren = wren_reg;
  assign oBusy       = busy_reg;
  assign finished    = finished_reg;
  assign oWhiteCount = count_reg;

endmodule

// File: tb/tb_adaptive_threshold.sv
// Bench for adaptive_threshold on a 4x4 image: table-driven uniform images,
// random images against a reference model, and multi-cycle corner cases.
module tb_adaptive_threshold;

  localparam int WB = 2;
  localparam int HB = 2;
  localparam int N  = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          iStart = 1'b0;
  logic [7:0]    iOffset = 8'd0;
  logic [WB-1:0] oReadCol;
  logic [HB-1:0] oReadRow;
  logic [7:0]    iImageData;
  logic [7:0]    iMeanData;
  logic [WB-1:0] oResultCol;
  logic [HB-1:0] oResultRow;
  logic [7:0]    oResultData;
  logic          oResultWren;
  logic          oBusy;
  logic          finished;
  logic [WB+HB:0] oWhiteCount;

  adaptive_threshold #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) dut (
    .clock       (clock),
    .reset       (reset),
    .iStart      (iStart),
    .iOffset     (iOffset),
    .oReadCol    (oReadCol),
    .oReadRow    (oReadRow),
    .iImageData  (iImageData),
    .iMeanData   (iMeanData),
    .oResultCol  (oResultCol),
    .oResultRow  (oResultRow),
    .oResultData (oResultData),
    .oResultWren (oResultWren),
    .oBusy       (oBusy),
    .finished    (finished),
    .oWhiteCount (oWhiteCount)
  );

  always #5 clock = ~clock;

  // Image and mean memories with one cycle of registered read latency.
  logic [7:0] img_mem [N];
  logic [7:0] mean_mem [N];
  always @(posedge clock) begin
    iImageData <= img_mem[{oReadRow, oReadCol}];
    iMeanData  <= mean_mem[{oReadRow, oReadCol}];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int addr; int data; int cyc;} wr_t;
  wr_t writes[$];
  always @(negedge clock) begin
    if (oResultWren === 1'b1)
      writes.push_back('{int'({oResultRow, oResultCol}), int'(oResultData), cyc});
  end

  int checks = 0;
  int failures = 0;
  int fin_cyc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_px(input int p, input int m, input int c);
    return (p + c > m) ? 255 : 0;
  endfunction

  task automatic fill_uniform(input int p, input int m);
    for (int i = 0; i < N; i++) begin
      img_mem[i]  = 8'(p);
      mean_mem[i] = 8'(m);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      img_mem[i]  = 8'($urandom_range(0, 255));
      mean_mem[i] = 8'($urandom_range(0, 255));
    end
  endtask

  // Raises iStart at a falling edge; k is the accepting rising edge.
  task automatic start_pass(input int c, input bit hold, output int k);
    @(negedge clock);
    writes.delete();
    iOffset = 8'(c);
    iStart  = 1'b1;
    k = cyc + 1;
    @(negedge clock);
    if (!hold) iStart = 1'b0;
  endtask

  task automatic wait_done(input string name);
    fin_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (finished === 1'b1) begin
        fin_cyc = cyc;
        break;
      end
    end
    if (fin_cyc < 0) chk({name, " finish_timeout"}, 0, 1);
  endtask

  task automatic check_pass(input string name, input int c, input int k);
    int whites = 0;
    int nw;
    chk({name, " nwrites"}, writes.size(), N);
    nw = (writes.size() < N) ? writes.size() : N;
    for (int i = 0; i < nw; i++) begin
      int exp_d;
      exp_d = model_px(img_mem[i], mean_mem[i], c);
      chk($sformatf("%s addr[%0d]", name, i), writes[i].addr, i);
      chk($sformatf("%s data[%0d]", name, i), writes[i].data, exp_d);
      chk($sformatf("%s cyc[%0d]", name, i), writes[i].cyc, k + 2 + i);
    end
    for (int i = 0; i < N; i++) if (model_px(img_mem[i], mean_mem[i], c) == 255) whites++;
    chk({name, " white_count"}, int'(oWhiteCount), whites);
    chk({name, " finish_cycle"}, fin_cyc, k + N + 2);
    chk({name, " busy_at_done"}, int'(oBusy), 0);
    chk({name, " wren_at_done"}, int'(oResultWren), 0);
  endtask

  typedef struct {int pixel; int mean; int c; int exp_data;} vec_t;
  vec_t vecs[6];

  initial begin
    int k;
    int k2;
    int cnt1;

    vecs[0] = '{100, 100, 0, 0};
    vecs[1] = '{100, 100, 1, 255};
    vecs[2] = '{0, 3, 5, 255};
    vecs[3] = '{255, 255, 255, 255};
    vecs[4] = '{10, 10, 0, 0};
    vecs[5] = '{0, 0, 0, 0};
    fill_uniform(0, 0);

    // Reset state.
    repeat (3) @(negedge clock);
    chk("reset wren", int'(oResultWren), 0);
    chk("reset busy", int'(oBusy), 0);
    chk("reset finished", int'(finished), 0);
    chk("reset count", int'(oWhiteCount), 0);
    chk("reset data", int'(oResultData), 0);
    chk("reset readaddr", int'({oReadRow, oReadCol}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle busy", int'(oBusy), 0);
    chk("idle wren", int'(oResultWren), 0);

    // Table: uniform images, expected pixel value given explicitly.
    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      fill_uniform(vecs[i].pixel, vecs[i].mean);
      start_pass(vecs[i].c, 1'b0, k);
      wait_done(nm);
      check_pass(nm, vecs[i].c, k);
      if (writes.size() > 0) chk({nm, " table_data"}, writes[0].data, vecs[i].exp_data);
      chk({nm, " table_count"}, int'(oWhiteCount), vecs[i].exp_data == 255 ? N : 0);
      $display("vector %0d pixel=%0d mean=%0d C=%0d count=%0d", i, vecs[i].pixel,
               vecs[i].mean, vecs[i].c, oWhiteCount);
    end

    // Random images against the model.
    for (int r = 0; r < 4; r++) begin
      int c;
      fill_random();
      c = $urandom_range(0, 80);
      start_pass(c, 1'b0, k);
      wait_done($sformatf("rand%0d", r));
      check_pass($sformatf("rand%0d", r), c, k);
      $display("random pass %0d C=%0d count=%0d", r, c, oWhiteCount);
    end

    // iStart pulse with a new offset during RUN is ignored.
    fill_uniform(100, 100);
    start_pass(0, 1'b0, k);
    repeat (3) @(negedge clock);
    iOffset = 8'd50;
    iStart  = 1'b1;
    @(negedge clock);
    iStart  = 1'b0;
    wait_done("midstart");
    check_pass("midstart", 0, k);
    $display("mid-run start pass count=%0d", oWhiteCount);

    // Reset after five writes aborts the pass.
    fill_random();
    start_pass(20, 1'b0, k);
    for (int i = 0; i < 40 && writes.size() < 5; i++) @(negedge clock);
    chk("abort reached5", writes.size(), 5);
    reset = 1'b1;
    #1;
    chk("abort wren", int'(oResultWren), 0);
    chk("abort busy", int'(oBusy), 0);
    chk("abort data", int'(oResultData), 0);
    chk("abort resaddr", int'({oResultRow, oResultCol}), 0);
    chk("abort count", int'(oWhiteCount), 0);
    chk("abort readaddr", int'({oReadRow, oReadCol}), 0);
    @(negedge clock);
    reset = 1'b0;
    writes.delete();
    repeat (30) @(negedge clock);
    chk("abort nowrites", writes.size(), 0);
    chk("abort finished", int'(finished), 0);
    start_pass(20, 1'b0, k);
    wait_done("restart");
    check_pass("restart", 20, k);
    $display("restart after reset count=%0d", oWhiteCount);

    // iStart held high through DONE immediately launches a second pass.
    fill_random();
    start_pass(30, 1'b1, k);
    wait_done("hold1");
    check_pass("hold1", 30, k);
    cnt1 = int'(oWhiteCount);
    @(negedge clock);
    chk("hold finished_clear", int'(finished), 0);
    chk("hold busy", int'(oBusy), 1);
    chk("hold count_clear", int'(oWhiteCount), 0);
    writes.delete();
    iStart = 1'b0;
    k2 = k + N + 3;
    wait_done("hold2");
    check_pass("hold2", 30, k2);
    chk("hold same_count", int'(oWhiteCount), cnt1);
    $display("held start passes count=%0d/%0d", cnt1, oWhiteCount);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
